// File: rtl/fft_pkg.sv
// Shared types and constants for the FFT frame sequencer: frame geometry,
// AXIS word layout, sequencer states and the real-to-complex packing helper.
package fft_pkg;

    localparam int FRAME_LEN = 512;
    localparam int IDX_W     = $clog2(FRAME_LEN);
    localparam int N_CH      = 4;
    localparam int CH_W      = 16;
    localparam int CFG_W     = 16;
    localparam int DATA_W    = N_CH * 2 * CH_W;
    localparam int DROP_W    = 16;

    typedef enum logic [2:0] {
        ST_RST_WAIT,
        ST_CONFIG,
        ST_GATE,
        ST_HOLD,
        ST_STREAM
    } fft_seq_state_t;

    typedef logic [N_CH-1:0][CH_W-1:0] sample_vec_t;

    // Each channel becomes one complex lane: real part in the low half,
    // zero imaginary part in the high half.
    function automatic logic [DATA_W-1:0] pack_real(input sample_vec_t samples);
        logic [DATA_W-1:0] word;
        word = '0;
        for (int c = 0; c < N_CH; c++) begin
            word[c*2*CH_W +: CH_W] = samples[c];
        end
        return word;
    endfunction

endpackage

// File: rtl/fifo_2deep.sv
// Two-entry register FIFO. mem0 is always the head. A push into a full FIFO
// is accepted when a pop happens in the same cycle; flush empties it.
module fifo_2deep #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem0;
    logic [W-1:0] mem1;
    logic [1:0]   count;
    logic         do_pop;
    logic         do_push;
    logic [1:0]   wr_pos;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign wr_pos  = count - {1'b0, do_pop};
    assign dout    = mem0;
    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);

    // Storage and occupancy; a write after the shift lands in the freed slot.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            mem0  <= '0;
            mem1  <= '0;
            count <= 2'd0;
        end else begin
            if (do_pop) begin
                mem0 <= mem1;
            end
            if (do_push) begin
                if (wr_pos == 2'd0) begin
                    mem0 <= din;
                end else begin
                    mem1 <= din;
                end
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Feeds the xfft core: packs 4 mic samples per AXIS beat, frames them with
// tlast, inserts config beats only between frames, throttles frames in flight
// against the FFT output drain and owns the core's active-low reset.
// Handshakes: a beat transfers on a clock edge where valid and ready are both
// high; valid never depends on ready and data is held while valid waits.
module fft_frame_sequencer
    import fft_pkg::*;
#(
    parameter logic [CFG_W-1:0] CFG_DEFAULT  = 16'h0001,
    parameter int               MAX_INFLIGHT = 2
) (
    input  logic                clk_in,
    input  logic                rst_in,
    input  sample_vec_t         sample_in,
    input  logic                sample_valid_in,
    input  logic [CFG_W-1:0]    cfg_word_in,
    input  logic                cfg_update_in,
    output logic                fft_aresetn_out,
    output logic [DATA_W-1:0]   s_data_tdata_out,
    output logic                s_data_tvalid_out,
    output logic                s_data_tlast_out,
    input  logic                s_data_tready_in,
    output logic [CFG_W-1:0]    s_cfg_tdata_out,
    output logic                s_cfg_tvalid_out,
    input  logic                s_cfg_tready_in,
    input  logic                m_done_in,
    output logic                frame_start_out,
    output logic [1:0]          inflight_out,
    output logic                overrun_out,
    output logic [DROP_W-1:0]   drop_count_out
);

    localparam logic [1:0]       MAX_IF   = 2'(MAX_INFLIGHT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_LEN - 1);

    fft_seq_state_t     state;
    logic [1:0]         rst_cnt;
    logic               aresetn_q;
    logic [CFG_W-1:0]   pending_cfg;
    logic               cfg_pend;
    logic [CFG_W-1:0]   cfg_data_q;
    logic               cfg_valid_q;
    logic [IDX_W-1:0]   idx;
    logic [1:0]         inflight;
    logic               overrun_q;
    logic [DROP_W-1:0]  drop_cnt;

    logic               fifo_full;
    logic               fifo_empty;
    logic [DATA_W-1:0]  fifo_head;
    logic               accept_state;
    logic               push;
    logic               tvalid;
    logic               pop;
    logic               tlast;
    logic               frame_done;
    logic               frame_start;
    logic               overflow;
    logic               discard;
    logic               drain;
    logic               below_limit;
    logic               flush;

    assign accept_state = (state == ST_CONFIG) || (state == ST_STREAM);
    assign push         = sample_valid_in && accept_state;
    assign tvalid       = !fifo_empty && (state == ST_STREAM);
    assign pop          = tvalid && s_data_tready_in;
    assign tlast        = (idx == LAST_IDX);
    assign frame_done   = pop && tlast;
    assign frame_start  = pop && (idx == '0);
    // Full FIFO with no beat leaving: the new sample has nowhere to go.
    assign overflow     = push && fifo_full && !pop;
    // GATE and HOLD do not accept samples, so anything arriving there is lost.
    assign discard      = overflow ||
                          (sample_valid_in && ((state == ST_GATE) || (state == ST_HOLD)));
    assign drain        = m_done_in && (inflight != 2'd0);
    assign below_limit  = (inflight < MAX_IF);
    // Holding throws away stale samples so the next frame starts on fresh data.
    assign flush        = (state == ST_HOLD);

    fifo_2deep #(
        .W (DATA_W)
    ) u_fifo (
        .clk   (clk_in),
        .rst   (rst_in),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (pack_real(sample_in)),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Core reset: low during rst_in and for two more cycles after release.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rst_cnt   <= 2'd0;
            aresetn_q <= 1'b0;
        end else if (!aresetn_q) begin
            rst_cnt <= rst_cnt + 2'd1;
            if (rst_cnt == 2'd1) begin
                aresetn_q <= 1'b1;
            end
        end
    end

    // Sequencer FSM with the registered config channel; updates always win.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= ST_RST_WAIT;
            pending_cfg <= CFG_DEFAULT;
            cfg_pend    <= 1'b1;
            cfg_data_q  <= '0;
            cfg_valid_q <= 1'b0;
        end else begin
            case (state)
                ST_RST_WAIT: begin
                    if (aresetn_q) begin
                        state <= ST_CONFIG;
                    end
                end
                ST_CONFIG: begin
                    if (!cfg_pend) begin
                        state <= ST_GATE;
                    end else if (!cfg_valid_q) begin
                        cfg_valid_q <= 1'b1;
                        cfg_data_q  <= pending_cfg;
                    end else if (s_cfg_tready_in) begin
                        cfg_valid_q <= 1'b0;
                        cfg_pend    <= 1'b0;
                        state       <= ST_GATE;
                    end
                end
                ST_GATE: begin
                    state <= below_limit ? ST_STREAM : ST_HOLD;
                end
                ST_HOLD: begin
                    if (below_limit) begin
                        state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (frame_done) begin
                        state <= cfg_pend ? ST_CONFIG : ST_GATE;
                    end
                end
                default: begin
                    state <= ST_RST_WAIT;
                end
            endcase
            if (cfg_update_in) begin
                pending_cfg <= cfg_word_in;
                cfg_pend    <= 1'b1;
            end
        end
    end

    // Beat index within the frame and frames pushed but not yet drained.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            idx      <= '0;
            inflight <= 2'd0;
        end else begin
            if (pop) begin
                idx <= idx + 1'b1;
            end
            case ({frame_done, drain})
                2'b10:   inflight <= inflight + 2'd1;
                2'b01:   inflight <= inflight - 2'd1;
                default: inflight <= inflight;
            endcase
        end
    end

    // Overrun flag (sticky until a frame starts) and saturating drop counter.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            overrun_q <= 1'b0;
            drop_cnt  <= '0;
        end else begin
            if (frame_start) begin
                overrun_q <= 1'b0;
            end
            if (overflow) begin
                overrun_q <= 1'b1;
            end
            if (discard && (drop_cnt != {DROP_W{1'b1}})) begin
                drop_cnt <= drop_cnt + 1'b1;
            end
        end
    end

    assign fft_aresetn_out   = aresetn_q;
    assign s_data_tdata_out  = fifo_head;
    assign s_data_tvalid_out = tvalid;
    assign s_data_tlast_out  = tlast;
    assign s_cfg_tdata_out   = cfg_data_q;
    assign s_cfg_tvalid_out  = cfg_valid_q;
    assign frame_start_out   = frame_start;
    assign inflight_out      = inflight;
    assign overrun_out       = overrun_q;
    assign drop_count_out    = drop_cnt;

endmodule

// File: tb/tb_fft_frame_sequencer.sv
// Directed bench for fft_frame_sequencer: reset release, framing, HOLD
// throttling, overrun, deferred config and mid-frame reset.
module tb_fft_frame_sequencer;
    import fft_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic               clk_in = 1'b0;
    logic               rst_in = 1'b1;
    sample_vec_t        sample_in = '0;
    logic               sample_valid_in = 1'b0;
    logic [CFG_W-1:0]   cfg_word_in = '0;
    logic               cfg_update_in = 1'b0;
    logic               fft_aresetn_out;
    logic [DATA_W-1:0]  s_data_tdata_out;
    logic               s_data_tvalid_out;
    logic               s_data_tlast_out;
    logic               s_data_tready_in = 1'b1;
    logic [CFG_W-1:0]   s_cfg_tdata_out;
    logic               s_cfg_tvalid_out;
    logic               s_cfg_tready_in = 1'b1;
    logic               m_done_in = 1'b0;
    logic               frame_start_out;
    logic [1:0]         inflight_out;
    logic               overrun_out;
    logic [DROP_W-1:0]  drop_count_out;

    always #5 clk_in = ~clk_in;

    fft_frame_sequencer u_dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .sample_in         (sample_in),
        .sample_valid_in   (sample_valid_in),
        .cfg_word_in       (cfg_word_in),
        .cfg_update_in     (cfg_update_in),
        .fft_aresetn_out   (fft_aresetn_out),
        .s_data_tdata_out  (s_data_tdata_out),
        .s_data_tvalid_out (s_data_tvalid_out),
        .s_data_tlast_out  (s_data_tlast_out),
        .s_data_tready_in  (s_data_tready_in),
        .s_cfg_tdata_out   (s_cfg_tdata_out),
        .s_cfg_tvalid_out  (s_cfg_tvalid_out),
        .s_cfg_tready_in   (s_cfg_tready_in),
        .m_done_in         (m_done_in),
        .frame_start_out   (frame_start_out),
        .inflight_out      (inflight_out),
        .overrun_out       (overrun_out),
        .drop_count_out    (drop_count_out)
    );

    // ---------------- scoreboard state ----------------
    int                 checks = 0;
    int                 errors = 0;
    logic [DATA_W-1:0]  exp_q[$];
    logic [CFG_W-1:0]   cfg_q[$];
    int                 bif = 0;
    int                 tlast_cnt = 0;
    int                 start_cnt = 0;
    int                 cfg_cnt = 0;
    int                 valid_cycles = 0;
    int                 sample_seq = 0;
    int                 exp_drop = 0;

    task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Output monitor: every data beat and config beat is checked on the falling edge.
    always @(negedge clk_in) begin
        if (!rst_in) begin
            if (s_data_tvalid_out) valid_cycles++;
            if (s_data_tvalid_out && s_data_tready_in) begin
                check_eq("tlast_pos", s_data_tlast_out, bif == FRAME_LEN - 1);
                check_eq("frame_start_pos", frame_start_out, bif == 0);
                if (exp_q.size() == 0) check_eq("beat_expected", exp_q.size() != 0, 1'b1);
                else check_eq("tdata", s_data_tdata_out, exp_q.pop_front());
                if (s_data_tlast_out) tlast_cnt++;
                if (frame_start_out) start_cnt++;
                bif = (bif + 1) % FRAME_LEN;
            end
            if (s_cfg_tvalid_out && s_cfg_tready_in) begin
                check_eq("cfg_at_boundary", bif, 0);
                if (cfg_q.size() == 0) check_eq("cfg_expected", cfg_q.size() != 0, 1'b1);
                else check_eq("cfg_data", s_cfg_tdata_out, cfg_q.pop_front());
                cfg_cnt++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_sample(input bit keep);
        sample_vec_t       s;
        logic [DATA_W-1:0] w;
        w = '0;
        for (int c = 0; c < N_CH; c++) begin
            s[c] = 16'(sample_seq * 7 + c * 1000) ^ ((c % 2 == 1) ? 16'h8000 : 16'h0000);
            w[c*32 +: 16] = s[c];
        end
        sample_seq++;
        @(posedge clk_in); #1;
        sample_in = s;
        sample_valid_in = 1'b1;
        @(posedge clk_in); #1;
        sample_valid_in = 1'b0;
        if (keep) exp_q.push_back(w);
        else exp_drop++;
        repeat (3) @(posedge clk_in);
    endtask

    task automatic send_n(input int n);
        for (int i = 0; i < n; i++) send_sample(1'b1);
    endtask

    task automatic pulse_done();
        @(posedge clk_in); #1;
        m_done_in = 1'b1;
        @(posedge clk_in); #1;
        m_done_in = 1'b0;
        repeat (2) @(posedge clk_in);
    endtask

    task automatic wait_cfg(input int n);
        for (int i = 0; i < 60 && cfg_cnt < n; i++) @(negedge clk_in);
        check_eq("cfg_beat_count", cfg_cnt, n);
    endtask

    task automatic do_reset();
        int lo;
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        sample_valid_in = 1'b0;
        cfg_update_in = 1'b0;
        m_done_in = 1'b0;
        repeat (3) @(posedge clk_in);
        exp_q.delete();
        cfg_q.delete();
        cfg_q.push_back(16'h0001);
        bif = 0;
        exp_drop = 0;
        @(negedge clk_in);
        check_eq("rst_aresetn", fft_aresetn_out, 1'b0);
        check_eq("rst_tvalid", s_data_tvalid_out, 1'b0);
        check_eq("rst_tlast", s_data_tlast_out, 1'b0);
        check_eq("rst_tdata", s_data_tdata_out, '0);
        check_eq("rst_cfg_tvalid", s_cfg_tvalid_out, 1'b0);
        check_eq("rst_cfg_tdata", s_cfg_tdata_out, '0);
        check_eq("rst_frame_start", frame_start_out, 1'b0);
        check_eq("rst_inflight", inflight_out, 2'd0);
        check_eq("rst_overrun", overrun_out, 1'b0);
        check_eq("rst_drop_count", drop_count_out, 16'd0);
        rst_in = 1'b0;
        lo = 0;
        for (int i = 0; i < 10; i++) begin
            if (fft_aresetn_out) break;
            lo++;
            @(negedge clk_in);
        end
        check_eq("aresetn_low_cycles", lo, 2);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset release, default config beat, then streaming.
        do_reset();
        wait_cfg(1);

        // Two full frames with tready high.
        send_n(2 * FRAME_LEN);
        check_eq("two_frames_tlast", tlast_cnt, 2);
        check_eq("two_frames_start", start_cnt, 2);
        check_eq("inflight_two", inflight_out, 2'd2);

        // Limit reached: HOLD discards every sample, nothing is presented.
        begin
            int v0;
            v0 = valid_cycles;
            for (int i = 0; i < 100; i++) send_sample(1'b0);
            check_eq("hold_no_tvalid", valid_cycles - v0, 0);
        end
        check_eq("hold_drop_count", drop_count_out, 16'd100);
        check_eq("hold_no_overrun", overrun_out, 1'b0);
        check_eq("hold_inflight", inflight_out, 2'd2);
        pulse_done();
        check_eq("drain_inflight", inflight_out, 2'd1);

        // Frame 3: backpressure for three sample pulses mid-frame.
        send_n(100);
        check_eq("frame3_started", start_cnt, 3);
        check_eq("pre_overrun", overrun_out, 1'b0);
        @(posedge clk_in); #1;
        s_data_tready_in = 1'b0;
        send_sample(1'b1);
        send_sample(1'b1);
        send_sample(1'b0);
        check_eq("overrun_set", overrun_out, 1'b1);
        check_eq("overrun_drop", drop_count_out, 16'(exp_drop));
        @(posedge clk_in); #1;
        s_data_tready_in = 1'b1;
        send_n(FRAME_LEN - 102);
        check_eq("frame3_tlast", tlast_cnt, 3);
        check_eq("overrun_sticky", overrun_out, 1'b1);
        check_eq("frame3_inflight", inflight_out, 2'd2);

        // Frame 4: config update mid-frame goes out only after tlast.
        pulse_done();
        pulse_done();
        check_eq("drained_inflight", inflight_out, 2'd0);
        send_sample(1'b1);
        check_eq("overrun_cleared", overrun_out, 1'b0);
        send_n(199);
        @(posedge clk_in); #1;
        cfg_word_in = 16'h00AB;
        cfg_update_in = 1'b1;
        cfg_q.push_back(16'h00AB);
        @(posedge clk_in); #1;
        cfg_update_in = 1'b0;
        check_eq("cfg_not_midframe", cfg_cnt, 1);
        send_n(FRAME_LEN - 200);
        wait_cfg(2);
        check_eq("frame4_tlast", tlast_cnt, 4);

        // Frame 5: reset lands at beat 300.
        send_n(300);
        check_eq("pre_reset_drop", drop_count_out, 16'(exp_drop));
        do_reset();
        wait_cfg(3);
        send_n(3);
        check_eq("post_reset_start", start_cnt, 6);
        check_eq("post_reset_inflight", inflight_out, 2'd0);
        check_eq("exp_q_drained", exp_q.size(), 0);
        check_eq("cfg_q_drained", cfg_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Watchdog so a stuck run still reports.
    initial begin
        #1000000;
        errors++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
